// File: rtl/vga_timing_receiver.sv
// VGA receive front end: samples sync/colour, recovers the beam position,
// checks line/frame timing and reports pixels once timing is locked.
// Optional build macro VGA_RX_CRC_EN adds a per-frame CRC-16-CCITT of the
// captured active pixels; without it frame_crc is held at zero.
module vga_timing_receiver #(
    parameter int unsigned HPIXELS     = 800,
    parameter int unsigned VLINES      = 521,
    parameter int unsigned HPULSE      = 96,
    parameter int unsigned VPULSE      = 2,
    parameter int unsigned HBP         = 144,
    parameter int unsigned HFP         = 784,
    parameter int unsigned VBP         = 31,
    parameter int unsigned VFP         = 511,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [5:0]  red,
    input  logic [5:0]  green,
    input  logic [5:0]  blue,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        px_valid,
    output logic [5:0]  px_red,
    output logic [5:0]  px_green,
    output logic [5:0]  px_blue,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [15:0] frame_crc
);
    localparam logic [9:0] SAT     = 10'd1023;
    localparam logic [9:0] H_LAST  = 10'(HPIXELS - 1);
    localparam logic [9:0] V_LAST  = 10'(VLINES - 1);
    localparam logic [9:0] H_PULSE = 10'(HPULSE);
    localparam logic [9:0] V_PULSE = 10'(VPULSE);
    localparam logic [9:0] H_BP    = 10'(HBP);
    localparam logic [9:0] H_FP    = 10'(HFP);
    localparam logic [9:0] V_BP    = 10'(VBP);
    localparam logic [9:0] V_FP    = 10'(VFP);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [17:0] rgb_q;
    logic [9:0]  hpos_q, vpos_q, hpos_d, vpos_d;
    logic        first_h_q, first_v_q;
    state_t      state_q;
    logic [3:0]  good_q;
    logic        locked_q, sync_err_q, frame_start_q, px_valid_q;
    logic [9:0]  px_x_q, px_y_q;
    logic [17:0] px_rgb_q;

    // Stage 1: register syncs and colour together; previous sync kept for edges.
    // Sync registers idle high so reset release never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            rgb_q     <= '0;
        end else begin
            hs_q      <= h_sync;
            vs_q      <= v_sync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            rgb_q     <= {red, green, blue};
        end
    end

    logic h_fall, h_rise, v_fall, v_rise;
    assign h_fall = hs_prev_q & ~hs_q;
    assign h_rise = ~hs_prev_q & hs_q;
    assign v_fall = vs_prev_q & ~vs_q;
    assign v_rise = ~vs_prev_q & vs_q;

    // Position of the sample currently in stage 1, both counters saturating.
    always_comb begin
        hpos_d = (hpos_q == SAT) ? SAT : hpos_q + 10'd1;
        if (h_fall) hpos_d = '0;
        vpos_d = vpos_q;
        if (v_fall)                       vpos_d = '0;
        else if (h_fall && vpos_q != SAT) vpos_d = vpos_q + 10'd1;
    end

    logic e_line, e_hwid, e_frame, e_vwid, e_tout, err;
    assign e_line  = h_fall & ~first_h_q & (hpos_q != H_LAST);
    assign e_hwid  = h_rise & (hpos_d != H_PULSE);
    assign e_frame = v_fall & ~first_v_q & (vpos_q != V_LAST);
    assign e_vwid  = v_rise & (vpos_d != V_PULSE);
    assign e_tout  = (hpos_d == SAT) & (hpos_q != SAT);
    assign err     = e_line | e_hwid | e_frame | e_vwid | e_tout;

    logic is_locked, go_search, frame_start_d, in_win, valid_d;
    assign is_locked     = (state_q == LOCKED);
    assign go_search     = err & (state_q != SEARCH);
    assign frame_start_d = v_fall & is_locked;
    assign in_win        = (hpos_d >= H_BP) && (hpos_d < H_FP) &&
                           (vpos_d >= V_BP) && (vpos_d < V_FP);
    assign valid_d       = is_locked & in_win;

    // Position history; the first edges after a loss of lock carry no length info.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q    <= '0;
            vpos_q    <= '0;
            first_h_q <= 1'b1;
            first_v_q <= 1'b1;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            if (go_search) begin
                first_h_q <= 1'b1;
                first_v_q <= 1'b1;
            end else begin
                if (h_fall) first_h_q <= 1'b0;
                if (v_fall) first_v_q <= 1'b0;
            end
        end
    end

    // Stage 2: pixel outputs, zeroed outside the locked active window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_valid_q <= 1'b0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            px_rgb_q   <= '0;
        end else begin
            px_valid_q <= valid_d;
            px_x_q     <= valid_d ? hpos_d - H_BP : '0;
            px_y_q     <= valid_d ? vpos_d - V_BP : '0;
            px_rgb_q   <= valid_d ? rgb_q : '0;
        end
    end

    // Lock FSM with registered status; locked shows the state the sample saw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            good_q        <= '0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            locked_q      <= is_locked;
            sync_err_q    <= go_search;
            frame_start_q <= frame_start_d;
            case (state_q)
                SEARCH: if (v_fall) begin
                    state_q <= VERIFY;
                    good_q  <= '0;
                end
                VERIFY: if (err) begin
                    state_q <= SEARCH;
                end else if (v_fall) begin
                    good_q <= good_q + 4'd1;
                    if (good_q + 4'd1 == LOCK_N) state_q <= LOCKED;
                end
                LOCKED: if (err) state_q <= SEARCH;
                default: state_q <= SEARCH;
            endcase
        end
    end

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [17:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 17; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc_acc_q, frame_crc_q;

    // Frame CRC: accumulate valid pixels, publish and restart at frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc_q   <= 16'hFFFF;
            frame_crc_q <= '0;
        end else if (go_search) begin
            crc_acc_q   <= 16'hFFFF;
            frame_crc_q <= '0;
        end else if (frame_start_d) begin
            frame_crc_q <= crc_acc_q;
            crc_acc_q   <= 16'hFFFF;
        end else if (valid_d) begin
            crc_acc_q   <= crc_step(crc_acc_q, rgb_q);
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = '0;
`endif

    assign px_valid    = px_valid_q;
    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign {px_red, px_green, px_blue} = px_rgb_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver using a scaled-down timing set so several
// frames fit in a short run. A transmitter model drives random colour; a
// sample-level reference model predicts every output each cycle.
module tb_vga_timing_receiver;
    localparam int HP = 40, VL = 20, HPUL = 4, VPUL = 2;
    localparam int HB = 8, HF = 36, VB = 3, VF = 18, LOCKN = 2;
    localparam int ST_S = 0, ST_V = 1, ST_L = 2;

    logic        clk = 1'b0, rst_n = 1'b1, h_sync = 1'b1, v_sync = 1'b1;
    logic [5:0]  red = '0, green = '0, blue = '0;
    logic [9:0]  px_x, px_y;
    logic        px_valid, locked, frame_start, sync_err;
    logic [5:0]  px_red, px_green, px_blue;
    logic [15:0] frame_crc;

    vga_timing_receiver #(
        .HPIXELS(HP), .VLINES(VL), .HPULSE(HPUL), .VPULSE(VPUL),
        .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue),
        .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .px_red(px_red), .px_green(px_green), .px_blue(px_blue),
        .locked(locked), .frame_start(frame_start), .sync_err(sync_err),
        .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, se_seen = 0, nvf = 0, vf3 = -1;
    bit prev_vin = 1'b1;

    // transmitter model state
    int gh = 0, gv = 0, short_vc = -1;
    bit stuck = 1'b0, zero_rgb = 1'b0, force_px = 1'b0;
    logic [17:0] force_rgb = '0;

    // reference model state
    int m_h, m_v, m_st, m_good;
    bit m_ph, m_pv, m_ign_h, m_ign_v;
    logic [15:0] m_fcrc;
`ifdef VGA_RX_CRC_EN
    logic [15:0] m_acc;
`endif
    logic [57:0] exp_o = '0;

    typedef struct {
        int hc; int vc; logic [17:0] rgb;
        logic ev; logic [9:0] ex; logic [9:0] ey;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [57:0] obs();
        return {px_valid, px_x, px_y, px_red, px_green, px_blue,
                locked, frame_start, sync_err, frame_crc};
    endfunction

    function automatic logic [15:0] crc18(input logic [15:0] c, input logic [17:0] d);
        int r, b;
        r = int'(c);
        for (int i = 17; i >= 0; i--) begin
            b = ((r >> 15) & 1) ^ int'(d[i]);
            r = (r << 1) & 'hFFFF;
            if (b != 0) r = r ^ 'h1021;
        end
        return 16'(r);
    endfunction

    task automatic check(input string name, input logic [57:0] got, input logic [57:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (sample %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_st = ST_S; m_good = 0;
        m_ph = 1'b1; m_pv = 1'b1; m_ign_h = 1'b1; m_ign_v = 1'b1;
        m_fcrc = '0;
`ifdef VGA_RX_CRC_EN
        m_acc = 16'hFFFF;
`endif
    endtask

    // One captured sample: returns the outputs it should produce 2 clocks on.
    task automatic m_step(input bit h, input bit v, input logic [17:0] rgb, output logic [57:0] o);
        bit hf, hr, vf, vr, err, lk, val, go;
        int nh, nv;
        hf = m_ph && !h;  hr = !m_ph && h;
        vf = m_pv && !v;  vr = !m_pv && v;
        nh = hf ? 0 : ((m_h + 1 > 1023) ? 1023 : m_h + 1);
        nv = vf ? 0 : (hf ? ((m_v + 1 > 1023) ? 1023 : m_v + 1) : m_v);
        err = (hf && !m_ign_h && m_h != HP - 1) || (hr && nh != HPUL) ||
              (vf && !m_ign_v && m_v != VL - 1) || (vr && nv != VPUL) ||
              (nh == 1023 && m_h != 1023);
        lk  = (m_st == ST_L);
        go  = err && (m_st != ST_S);
        val = lk && nh >= HB && nh < HF && nv >= VB && nv < VF;
`ifdef VGA_RX_CRC_EN
        if (go) begin m_acc = 16'hFFFF; m_fcrc = '0; end
        else if (vf && lk) begin m_fcrc = m_acc; m_acc = 16'hFFFF; end
        else if (val) m_acc = crc18(m_acc, rgb);
`endif
        o = {val, val ? 10'(nh - HB) : 10'd0, val ? 10'(nv - VB) : 10'd0,
             val ? rgb : 18'd0, lk, vf && lk, go, m_fcrc};
        if (m_st == ST_S) begin
            if (vf) begin m_st = ST_V; m_good = 0; end
        end else if (err) begin
            m_st = ST_S;
        end else if (vf && m_st == ST_V) begin
            m_good++;
            if (m_good == LOCKN) m_st = ST_L;
        end
        if (go) begin m_ign_h = 1'b1; m_ign_v = 1'b1; end
        else begin
            if (hf) m_ign_h = 1'b0;
            if (vf) m_ign_v = 1'b0;
        end
        m_h = nh; m_v = nv; m_ph = h; m_pv = v;
    endtask

    // Drive one sample, check the previous sample's outputs, advance transmitter.
    task automatic tick();
        bit h, v;
        logic [17:0] rgb;
        logic [57:0] got;
        h = stuck ? 1'b1 : (gh >= HPUL);
        v = stuck ? 1'b1 : (gv >= VPUL);
        rgb = force_px ? force_rgb : (zero_rgb ? 18'd0 : 18'($urandom));
        force_px = 1'b0;
        h_sync = h; v_sync = v; {red, green, blue} = rgb;
        if (prev_vin && !v) begin nvf++; if (nvf == 3) vf3 = cyc; end
        prev_vin = v;
        @(posedge clk); #1;
        got = obs();
        if (sync_err) se_seen++;
        check("cycle", got, exp_o);
        m_step(h, v, rgb, exp_o);
        cyc++;
        gh++;
        if (gh >= ((gv == short_vc) ? HP - 1 : HP)) begin
            if (gv == short_vc) short_vc = -1;
            gh = 0;
            gv = (gv + 1) % VL;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; #1;
        check("reset_zero", obs(), 58'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        m_step(1'b1, 1'b1, 18'd0, exp_o);
        nvf = 0; prev_vin = 1'b1; cyc = 0; vf3 = -1;
    endtask

    task automatic run_until_locked(input string name, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (locked) begin at = cyc - 1; break; end
        end
        n_tests++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s: locked stayed 0 for %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic goto_pos(input int hc, input int vc);
        int k;
        k = 0;
        while (!(gh == hc && gv == vc) && k < 2000) begin tick(); k++; end
        if (k >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL goto_pos: position %0d,%0d not reached, expected within 2000", hc, vc);
        end
    endtask

    task automatic wait_flag(input string name, input int which, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = (which == 0) ? sync_err : frame_start;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: no pulse in %0d cycles, expected one", name, budget);
        end
    endtask

    initial begin
        int at;
        logic [57:0] g;
`ifdef VGA_RX_CRC_EN
        logic [15:0] crc0, crc1, zref;
`endif
        vecs[0] = '{8,  3,  18'h3F000, 1'b1, 10'd0,  10'd0};
        vecs[1] = '{35, 17, 18'h01AD5, 1'b1, 10'd27, 10'd14};
        vecs[2] = '{36, 17, 18'h3FFFF, 1'b0, 10'd0,  10'd0};
        vecs[3] = '{7,  4,  18'h15555, 1'b0, 10'd0,  10'd0};
        vecs[4] = '{8,  18, 18'h2AAAA, 1'b0, 10'd0,  10'd0};
        vecs[5] = '{8,  2,  18'h3FFFF, 1'b0, 10'd0,  10'd0};
        vecs[6] = '{20, 10, 18'h128D6, 1'b1, 10'd12, 10'd7};

        #2;
        do_reset();

        // clean timing: lock one clock after the third v falling edge
        se_seen = 0;
        run_until_locked("initial_lock", 4000, at);
        check("lock_latency", 58'(at - vf3), 58'd2);
        repeat (HP * VL) tick();
        check("no_err_clean", 58'(se_seen), 58'd0);

        // positional vectors while locked
        foreach (vecs[i]) begin
            goto_pos(vecs[i].hc, vecs[i].vc);
            force_px = 1'b1; force_rgb = vecs[i].rgb;
            tick();
            tick();
            g = {px_valid, px_x, px_y, px_red, px_green, px_blue, 19'd0};
            check("vector", g, {vecs[i].ev, vecs[i].ex, vecs[i].ey,
                                vecs[i].ev ? vecs[i].rgb : 18'd0, 19'd0});
        end

        // one short line: error pulse while still locked, then lock drops
        goto_pos(0, 3);
        short_vc = 5;
        wait_flag("short_line_err", 0, 2 * HP * VL);
        check("locked_at_err", 58'(locked), 58'd1);
        tick();
        check("unlock_after_err", {56'd0, locked, px_valid}, 58'd0);
        run_until_locked("relock_short", 4 * HP * VL, at);

        // hsync stuck high: timeout, then recovery
        goto_pos(HPUL + 1, VPUL + 3);
        stuck = 1'b1;
        wait_flag("timeout_err", 0, 1100);
        tick();
        check("unlock_timeout", 58'(locked), 58'd0);
        repeat (100) tick();
        stuck = 1'b0;
        run_until_locked("relock_timeout", 5 * HP * VL, at);

        // asynchronous reset mid-line
        goto_pos(20, 9);
        do_reset();
        se_seen = 0;
        run_until_locked("relock_reset", 4 * HP * VL, at);
        check("reset_lock_latency", 58'(at - vf3), 58'd2);
        check("no_err_after_reset", 58'(se_seen), 58'd0);

`ifdef VGA_RX_CRC_EN
        wait_flag("crc_fs0", 1, 2 * HP * VL);
        zero_rgb = 1'b1;
        wait_flag("crc_fs1", 1, 2 * HP * VL);
        crc0 = frame_crc;
        zref = 16'hFFFF;
        for (int i = 0; i < (HF - HB) * (VF - VB); i++) zref = crc18(zref, 18'd0);
        check("crc_zero_frame", 58'(crc0), 58'(zref));
        goto_pos(20, 10);
        force_px = 1'b1; force_rgb = 18'h01000;
        wait_flag("crc_fs2", 1, 2 * HP * VL);
        crc1 = frame_crc;
        n_tests++;
        if (crc1 == crc0) begin
            n_fail++;
            $display("FAIL crc_pixel_change: got %h, expected a value other than %h", crc1, crc0);
        end
        zero_rgb = 1'b0;
`endif

        repeat (20) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
